// File: rtl/uart_io_controller_pkg.sv
// Shared constants for the UART I/O controller: register addresses, status-word
// bit positions and FSM state encodings.
package uart_io_controller_pkg;

  localparam int WIDTH = 32;

  localparam logic [15:0] UART_TX_ADDR   = 16'h00F0;
  localparam logic [15:0] UART_RX_ADDR   = 16'h00F1;
  localparam logic [15:0] UART_CTRL_ADDR = 16'h00F2;

  localparam int ST_RX_HEAD_LSB = 8;
  localparam int ST_TX_OVF      = 4;
  localparam int ST_RX_OVF      = 3;
  localparam int ST_TX_FULL     = 2;
  localparam int ST_TX_EMPTY    = 1;
  localparam int ST_RX_VALID    = 0;

  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_HOLD = 2'd1;
  localparam logic [1:0] TX_WAIT = 2'd2;

  localparam logic [0:0] RX_IDLE = 1'b0;
  localparam logic [0:0] RX_ACK  = 1'b1;

  function automatic logic [WIDTH-1:0] build_status(input logic [7:0] rx_head,
                                                    input logic tx_ovf,
                                                    input logic rx_ovf,
                                                    input logic tx_full,
                                                    input logic tx_empty,
                                                    input logic rx_valid);
    logic [WIDTH-1:0] word;
    word = {WIDTH{1'b0}};
    word[ST_RX_HEAD_LSB +: 8] = rx_head;
    word[ST_TX_OVF]   = tx_ovf;
    word[ST_RX_OVF]   = rx_ovf;
    word[ST_TX_FULL]  = tx_full;
    word[ST_TX_EMPTY] = tx_empty;
    word[ST_RX_VALID] = rx_valid;
    return word;
  endfunction

endpackage

// File: rtl/uart_io_controller_sync_fifo.sv
// Synchronous FIFO with combinational head, flush, and look-ahead of the
// post-edge count and head so the owner can register status without extra latency.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       active_low_reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     count_next,
  output logic [WIDTH-1:0]           head_next
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] C_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [AW-1:0] A_ONE  = AW'(1'b1);
  localparam logic [AW-1:0] A_ZERO = {AW{1'b0}};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r, head_idx_s;
  logic [CW-1:0]    count_r;
  logic             push_s, pop_s;

  // A pop frees a slot in the same cycle, so a push into a full FIFO can still land.
  assign pop_s  = pop && (count_r != C_ZERO);
  assign push_s = push && ((count_r != C_FULL) || pop_s);

  assign count = count_r;
  assign full  = (count_r == C_FULL);
  assign empty = (count_r == C_ZERO);
  assign dout  = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
  assign head_idx_s = rd_ptr_r + (pop_s ? A_ONE : A_ZERO);

  // Occupancy after the coming edge.
  always_comb begin
    count_next = count_r;
    if (flush) begin
      count_next = C_ZERO;
    end else if (push_s && !pop_s) begin
      count_next = count_r + C_ONE;
    end else if (pop_s && !push_s) begin
      count_next = count_r - C_ONE;
    end else begin
      count_next = count_r;
    end
  end

  // Head byte after the coming edge; the new head is the incoming byte when it lands in the head slot.
  always_comb begin
    head_next = {WIDTH{1'b0}};
    if (count_next == C_ZERO) begin
      head_next = {WIDTH{1'b0}};
    end else if (push_s && (head_idx_s == wr_ptr_r)) begin
      head_next = din;
    end else begin
      head_next = mem_r[head_idx_s];
    end
  end

  // Pointer and count state; flush overrides any same-cycle push or pop.
  always_ff @(posedge clock or negedge active_low_reset) begin
    if (!active_low_reset) begin
      wr_ptr_r <= A_ZERO;
      rd_ptr_r <= A_ZERO;
      count_r  <= C_ZERO;
    end else if (flush) begin
      wr_ptr_r <= A_ZERO;
      rd_ptr_r <= A_ZERO;
      count_r  <= C_ZERO;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + A_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + A_ONE;
      count_r <= count_next;
    end
  end

  // Storage array.
  always_ff @(posedge clock) begin
    if (push_s && !flush) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/uart_io_controller.sv
// Buffers j2 core I/O accesses to a buart: TX/RX FIFOs, handshake sequencers,
// and a registered status/data word returned on io_data_in.
module uart_io_controller
  import uart_io_controller_pkg::*;
#(
  parameter int          TX_DEPTH  = 16,
  parameter int          RX_DEPTH  = 16,
  parameter logic [15:0] TX_ADDR   = UART_TX_ADDR,
  parameter logic [15:0] RX_ADDR   = UART_RX_ADDR,
  parameter logic [15:0] CTRL_ADDR = UART_CTRL_ADDR
) (
  input  logic             clock,
  input  logic             active_low_reset,
  input  logic             io_write_enable,
  input  logic [15:0]      memory_address,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] io_data_in,
  output logic             uart_wr,
  output logic [7:0]       uart_tx_data,
  input  logic             uart_busy,
  output logic             uart_rd,
  input  logic             uart_valid,
  input  logic [7:0]       uart_rx_data
);

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;

  logic [1:0]       rst_sync_r;
  logic             rst_n_s;
  logic             wr_en_r;
  logic [15:0]      addr_r;
  logic [7:0]       byte_r;
  logic             tx_push_s, rx_pop_s, ctrl_s, clr_s, flush_s;
  logic             tx_issue_s, tx_drop_s, rx_take_s, rx_drop_s;
  logic             tx_ovf_r, rx_ovf_r, tx_ovf_next_s, rx_ovf_next_s;
  logic [1:0]       tx_state_r;
  logic [0:0]       rx_state_r;
  logic             uart_wr_r, uart_rd_r;
  logic [7:0]       uart_tx_data_r;
  logic [WIDTH-1:0] io_data_in_r;
  logic [7:0]       tx_head_s, tx_head_next_s, rx_dout_s, rx_head_next_s;
  logic             tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
  logic [TX_CW-1:0] tx_count_s, tx_count_next_s;
  logic [RX_CW-1:0] rx_count_s, rx_count_next_s;
  logic             unused_s;

  // Reset asserts asynchronously and releases on the second clock edge.
  always_ff @(posedge clock or negedge active_low_reset) begin
    if (!active_low_reset) rst_sync_r <= 2'b00;
    else                   rst_sync_r <= {rst_sync_r[0], 1'b1};
  end
  assign rst_n_s = rst_sync_r[1];

  // Core write strobe, address and low data byte are registered before decode.
  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      wr_en_r <= 1'b0;
      addr_r  <= 16'h0000;
      byte_r  <= 8'h00;
    end else begin
      wr_en_r <= io_write_enable;
      addr_r  <= memory_address;
      byte_r  <= data[7:0];
    end
  end

  assign tx_push_s  = wr_en_r && (addr_r == TX_ADDR);
  assign rx_pop_s   = wr_en_r && (addr_r == RX_ADDR);
  assign ctrl_s     = wr_en_r && (addr_r == CTRL_ADDR);
  assign clr_s      = ctrl_s && byte_r[0];
  assign flush_s    = ctrl_s && byte_r[1];
  assign tx_issue_s = (tx_state_r == TX_IDLE) && !tx_empty_s && !uart_busy;
  assign tx_drop_s  = tx_push_s && tx_full_s && !tx_issue_s;
  assign rx_take_s  = (rx_state_r == RX_IDLE) && uart_valid;
  assign rx_drop_s  = rx_take_s && rx_full_s && !rx_pop_s && !flush_s;

  // Sticky overflow flags: a set in the same cycle as a clear wins.
  always_comb begin
    tx_ovf_next_s = tx_ovf_r;
    rx_ovf_next_s = rx_ovf_r;
    if (tx_drop_s)  tx_ovf_next_s = 1'b1;
    else if (clr_s) tx_ovf_next_s = 1'b0;
    else            tx_ovf_next_s = tx_ovf_r;
    if (rx_drop_s)  rx_ovf_next_s = 1'b1;
    else if (clr_s) rx_ovf_next_s = 1'b0;
    else            rx_ovf_next_s = rx_ovf_r;
  end

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clock(clock), .active_low_reset(rst_n_s),
    .push(tx_push_s), .pop(tx_issue_s), .flush(flush_s), .din(byte_r),
    .dout(tx_head_s), .full(tx_full_s), .empty(tx_empty_s),
    .count(tx_count_s), .count_next(tx_count_next_s), .head_next(tx_head_next_s)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clock(clock), .active_low_reset(rst_n_s),
    .push(rx_take_s), .pop(rx_pop_s), .flush(flush_s), .din(uart_rx_data),
    .dout(rx_dout_s), .full(rx_full_s), .empty(rx_empty_s),
    .count(rx_count_s), .count_next(rx_count_next_s), .head_next(rx_head_next_s)
  );

  assign unused_s = ^{data[WIDTH-1:8], tx_count_s, tx_head_next_s, rx_dout_s, rx_empty_s, rx_count_s};

  // TX sequencer: issue a byte, give busy one cycle to rise, then wait for it to fall.
  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      tx_state_r     <= TX_IDLE;
      uart_wr_r      <= 1'b0;
      uart_tx_data_r <= 8'h00;
    end else begin
      uart_wr_r <= tx_issue_s;
      if (tx_issue_s) uart_tx_data_r <= tx_head_s;
      case (tx_state_r)
        TX_IDLE: if (tx_issue_s) tx_state_r <= TX_HOLD;
        TX_HOLD: tx_state_r <= TX_WAIT;
        TX_WAIT: if (!uart_busy) tx_state_r <= TX_IDLE;
        default: tx_state_r <= TX_IDLE;
      endcase
    end
  end

  // RX sequencer: acknowledge each byte, then skip a cycle while buart drops valid.
  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      rx_state_r <= RX_IDLE;
      uart_rd_r  <= 1'b0;
    end else begin
      uart_rd_r <= rx_take_s;
      case (rx_state_r)
        RX_IDLE: if (rx_take_s) rx_state_r <= RX_ACK;
        RX_ACK:  rx_state_r <= RX_IDLE;
        default: rx_state_r <= RX_IDLE;
      endcase
    end
  end

  // Flags and status word are built from post-edge FIFO state to save a cycle of latency.
  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      tx_ovf_r     <= 1'b0;
      rx_ovf_r     <= 1'b0;
      io_data_in_r <= build_status(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end else begin
      tx_ovf_r     <= tx_ovf_next_s;
      rx_ovf_r     <= rx_ovf_next_s;
      io_data_in_r <= build_status(rx_head_next_s, tx_ovf_next_s, rx_ovf_next_s,
                                   tx_count_next_s == TX_CW'(TX_DEPTH),
                                   tx_count_next_s == {TX_CW{1'b0}},
                                   rx_count_next_s != {RX_CW{1'b0}});
    end
  end

  assign io_data_in   = io_data_in_r;
  assign uart_wr      = uart_wr_r;
  assign uart_tx_data = uart_tx_data_r;
  assign uart_rd      = uart_rd_r;

endmodule
